// File: rtl/bcu_tile_port_pkg.sv
// bcu_tile_port_pkg: shared sizes, FSM/select types and the byte-strobe merge helper
package bcu_tile_port_pkg;
  localparam int TILE_ADDR_W = 14;
  localparam int N_SCROLL = 8;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;
  typedef enum logic [2:0] {SEL_ATTR, SEL_NUM, SEL_OFS, SEL_SCROLL, SEL_FLIP} sel_t;
  function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] wd,
                                          input logic uds_n, input logic lds_n);
    return {uds_n ? old[15:8] : wd[15:8], lds_n ? old[7:0] : wd[7:0]};
  endfunction
endpackage

// File: rtl/bcu_tile_ram.sv
// bcu_tile_ram: true dual-port tile VRAM, byte-writable port A, read-only port B, read-first
module bcu_tile_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [3:0]        a_be,
  input  logic [31:0]       a_wdata,
  output logic [31:0]       a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [31:0]       b_rdata
);
  logic [31:0] mem [1<<ADDR_W];
  logic [31:0] a_rdata_q, b_rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    a_rdata_q <= mem[a_addr];
    b_rdata_q <= mem[b_addr];
  end
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule

// File: rtl/bcu_tile_port.sv
// bcu_tile_port: M68K pointer-indirect tile VRAM port with scroll/flip registers and DTACK
module bcu_tile_port
  import bcu_tile_port_pkg::*;
#(
  parameter int ADDR_W   = TILE_ADDR_W,
  parameter int N_SCROLL = bcu_tile_port_pkg::N_SCROLL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            cpu_a,
  input  logic                  cpu_rw,
  input  logic                  cpu_uds_n,
  input  logic                  cpu_lds_n,
  input  logic [15:0]           cpu_dout,
  input  logic                  bcu_flip_cs,
  input  logic                  tile_ofs_cs,
  input  logic                  tile_attr_cs,
  input  logic                  tile_num_cs,
  input  logic                  scroll_cs,
  output logic [15:0]           cpu_din,
  output logic                  dtack_n,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic [31:0]           vid_data,
  output logic [16*N_SCROLL-1:0] scroll,
  output logic [15:0]           bcu_flip
);
  state_t state_q, state_d;
  sel_t sel_q, sel_d, cs_sel;
  logic rw_q, rw_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d, cs_prev_q, cs_prev_d;
  logic dtack_n_q, dtack_n_d;
  logic [3:0] a_q, a_d;
  logic [15:0] wdata_q, wdata_d, cpu_din_q, cpu_din_d, tile_ofs_q, tile_ofs_d, flip_q, flip_d;
  logic [15:0] scroll_q [N_SCROLL];
  logic [15:0] scroll_d [N_SCROLL];
  logic any_cs, ram_we;
  logic [3:0] ram_be;
  logic [31:0] ram_rdata;
  logic [15:0] rdata;

  assign any_cs = bcu_flip_cs | tile_ofs_cs | tile_attr_cs | tile_num_cs | scroll_cs;
  assign cs_sel = tile_attr_cs ? SEL_ATTR : tile_num_cs ? SEL_NUM : tile_ofs_cs ? SEL_OFS :
                  scroll_cs ? SEL_SCROLL : SEL_FLIP;
  assign ram_we = state_q == ADDR && !rw_q && (sel_q == SEL_ATTR || sel_q == SEL_NUM);
  assign ram_be = !ram_we ? 4'b0000 :
                  sel_q == SEL_ATTR ? {~uds_n_q, ~lds_n_q, 2'b00} : {2'b00, ~uds_n_q, ~lds_n_q};
  assign rdata = sel_q == SEL_ATTR ? ram_rdata[31:16] :
                 sel_q == SEL_NUM ? ram_rdata[15:0] :
                 sel_q == SEL_OFS ? tile_ofs_q :
                 sel_q == SEL_SCROLL ? scroll_q[a_q[3:1]] : flip_q;

  bcu_tile_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .a_addr  (tile_ofs_q[ADDR_W-1:0]),
    .a_be    (ram_be),
    .a_wdata ({wdata_q, wdata_q}),
    .a_rdata (ram_rdata),
    .b_addr  (vid_addr),
    .b_rdata (vid_data)
  );

  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    rw_d = rw_q;
    uds_n_d = uds_n_q;
    lds_n_d = lds_n_q;
    a_d = a_q;
    wdata_d = wdata_q;
    cs_prev_d = any_cs;
    cpu_din_d = cpu_din_q;
    dtack_n_d = dtack_n_q;
    tile_ofs_d = tile_ofs_q;
    flip_d = flip_q;
    scroll_d = scroll_q;
    case (state_q)
      IDLE: if (any_cs && !cs_prev_q) begin
        sel_d = cs_sel;
        rw_d = cpu_rw;
        uds_n_d = cpu_uds_n;
        lds_n_d = cpu_lds_n;
        a_d = cpu_a;
        wdata_d = cpu_dout;
        state_d = ADDR;
      end
      ADDR: state_d = DATA;
      DATA: begin
        state_d = ACK;
        dtack_n_d = 1'b0;
        if (rw_q) cpu_din_d = rdata;
        else if (sel_q == SEL_OFS) tile_ofs_d = merge16(tile_ofs_q, wdata_q, uds_n_q, lds_n_q);
        else if (sel_q == SEL_SCROLL)
          scroll_d[a_q[3:1]] = merge16(scroll_q[a_q[3:1]], wdata_q, uds_n_q, lds_n_q);
        else if (sel_q == SEL_FLIP) flip_d = merge16(flip_q, wdata_q, uds_n_q, lds_n_q);
      end
      default: if (!any_cs) begin
        dtack_n_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q <= SEL_FLIP;
      rw_q <= 1'b1;
      uds_n_q <= 1'b1;
      lds_n_q <= 1'b1;
      a_q <= '0;
      wdata_q <= '0;
      cs_prev_q <= 1'b0;
      cpu_din_q <= '0;
      dtack_n_q <= 1'b1;
      tile_ofs_q <= '0;
      flip_q <= '0;
      scroll_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rw_q <= rw_d;
      uds_n_q <= uds_n_d;
      lds_n_q <= lds_n_d;
      a_q <= a_d;
      wdata_q <= wdata_d;
      cs_prev_q <= cs_prev_d;
      cpu_din_q <= cpu_din_d;
      dtack_n_q <= dtack_n_d;
      tile_ofs_q <= tile_ofs_d;
      flip_q <= flip_d;
      scroll_q <= scroll_d;
    end
  end

  for (genvar i = 0; i < N_SCROLL; i++) begin : g_scroll
    assign scroll[16*i +: 16] = scroll_q[i];
  end
  assign cpu_din = cpu_din_q;
  assign dtack_n = dtack_n_q;
  assign bcu_flip = flip_q;
endmodule

// File: tb/tb_bcu_tile_port.sv
// tb_bcu_tile_port: directed scoreboard bench for the BCU tile VRAM port
module tb_bcu_tile_port;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] cpu_a = '0;
  logic cpu_rw = 1'b1, cpu_uds_n = 1'b1, cpu_lds_n = 1'b1;
  logic [15:0] cpu_dout = '0;
  logic bcu_flip_cs = 0, tile_ofs_cs = 0, tile_attr_cs = 0, tile_num_cs = 0, scroll_cs = 0;
  logic [15:0] cpu_din, bcu_flip;
  logic dtack_n;
  logic [13:0] vid_addr = '0;
  logic [31:0] vid_data;
  logic [127:0] scroll;
  int checks = 0, errors = 0;
  logic [15:0] exp_q [$];

  localparam int S_ATTR = 0, S_NUM = 1, S_OFS = 2, S_SCR = 3, S_FLIP = 4, S_NONE = -1;

  bcu_tile_port dut (
    .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_rw(cpu_rw), .cpu_uds_n(cpu_uds_n),
    .cpu_lds_n(cpu_lds_n), .cpu_dout(cpu_dout), .bcu_flip_cs(bcu_flip_cs),
    .tile_ofs_cs(tile_ofs_cs), .tile_attr_cs(tile_attr_cs), .tile_num_cs(tile_num_cs),
    .scroll_cs(scroll_cs), .cpu_din(cpu_din), .dtack_n(dtack_n), .vid_addr(vid_addr),
    .vid_data(vid_data), .scroll(scroll), .bcu_flip(bcu_flip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_cs(input int s);
    tile_attr_cs = (s == S_ATTR);
    tile_num_cs = (s == S_NUM);
    tile_ofs_cs = (s == S_OFS);
    scroll_cs = (s == S_SCR);
    bcu_flip_cs = (s == S_FLIP);
  endtask

  task automatic access(input int s, input logic rw, input logic [3:0] a, input logic [15:0] d,
                        input logic un, input logic ln, input int hold, input string tag);
    int n;
    logic [15:0] e;
    cpu_rw = rw; cpu_a = a; cpu_dout = d; cpu_uds_n = un; cpu_lds_n = ln;
    drive_cs(s);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dtack_n && n < 20);
    check({tag, " latency"}, n, 3);
    if (rw) begin
      e = exp_q.pop_front();
      check({tag, " rdata"}, {16'h0, cpu_din}, {16'h0, e});
    end
    repeat (hold) begin @(posedge clk); #1; check({tag, " hold"}, dtack_n, 0); end
    drive_cs(S_NONE);
    cpu_uds_n = 1'b1; cpu_lds_n = 1'b1; cpu_rw = 1'b1;
    @(posedge clk); #1;
    check({tag, " release"}, dtack_n, 1);
  endtask

  task automatic wr(input int s, input logic [3:0] a, input logic [15:0] d, input string tag);
    access(s, 1'b0, a, d, 1'b0, 1'b0, 0, tag);
  endtask

  task automatic rd(input int s, input logic [3:0] a, input logic [15:0] e, input string tag);
    exp_q.push_back(e);
    access(s, 1'b1, a, 16'h0, 1'b0, 1'b0, 0, tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset dtack_n", dtack_n, 1);
    check("reset cpu_din", cpu_din, 0);
    check("reset flip", bcu_flip, 0);
    check("reset scroll lo", scroll[63:0], 0);
    check("reset scroll hi", scroll[127:64], 0);
    reset = 1'b0;
    @(posedge clk); #1;

    wr(S_OFS, 0, 16'h0123, "ofs wr");
    rd(S_OFS, 0, 16'h0123, "ofs rd");
    wr(S_ATTR, 0, 16'hA5A5, "attr wr");
    wr(S_NUM, 0, 16'h5A5A, "num wr");
    rd(S_ATTR, 0, 16'hA5A5, "attr rd");
    rd(S_NUM, 0, 16'h5A5A, "num rd");
    vid_addr = 14'h0123;
    @(posedge clk); #1;
    check("vid 0x123", vid_data, 32'hA5A55A5A);

    cpu_rw = 1'b0; cpu_dout = 16'h1111; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    drive_cs(S_ATTR);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("vid old on collide", vid_data, 32'hA5A55A5A);
    @(posedge clk); #1;
    check("vid new after write", vid_data, 32'h11115A5A);
    check("collide dtack", dtack_n, 0);
    drive_cs(S_NONE);
    @(posedge clk); #1;
    check("collide release", dtack_n, 1);

    wr(S_NUM, 0, 16'h1234, "num 1234");
    access(S_NUM, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0, 0, "lds only");
    rd(S_NUM, 0, 16'h12FF, "byte mask");
    access(S_NUM, 1'b0, 0, 16'h0000, 1'b1, 1'b1, 0, "no strobe");
    rd(S_NUM, 0, 16'h12FF, "no strobe rd");

    wr(S_OFS, 0, 16'h4005, "ofs wrap");
    rd(S_OFS, 0, 16'h4005, "ofs wrap rd");
    wr(S_ATTR, 0, 16'hBEEF, "attr wrap");
    vid_addr = 14'h0005;
    @(posedge clk); #1;
    check("vid wrap attr", {16'h0, vid_data[31:16]}, 32'h0000BEEF);
    rd(S_ATTR, 0, 16'hBEEF, "attr wrap rd");

    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      wr(S_SCR, {idx, 1'b0}, 16'h0100 + 16'(i), "scroll wr");
    end
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      check("scroll out", {16'h0, scroll[16*i +: 16]}, 32'h0100 + 32'(i));
      rd(S_SCR, {idx, 1'b0}, 16'h0100 + 16'(i), "scroll rd");
    end

    wr(S_FLIP, 0, 16'h8001, "flip wr");
    check("flip out", bcu_flip, 16'h8001);
    rd(S_FLIP, 0, 16'h8001, "flip rd");

    access(S_FLIP, 1'b0, 0, 16'h0F0F, 1'b0, 1'b0, 10, "hold");
    rd(S_FLIP, 0, 16'h0F0F, "second pulse");

    cpu_rw = 1'b1; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    drive_cs(S_NUM);
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset dtack", dtack_n, 0);
    reset = 1'b1;
    drive_cs(S_NONE);
    #1;
    check("mid-ack reset dtack", dtack_n, 1);
    check("mid-ack reset flip", bcu_flip, 0);
    check("mid-ack reset scroll", {32'h0, scroll[127:96]}, 0);
    check("mid-ack reset scroll0", scroll[31:0], 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    wr(S_NUM, 0, 16'h0C0C, "num ofs0");
    cpu_rw = 1'b0; cpu_dout = 16'h7777; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    drive_cs(S_NUM);
    @(posedge clk); #1;
    reset = 1'b1;
    drive_cs(S_NONE);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("dropped write dtack", dtack_n, 1);
    rd(S_NUM, 0, 16'h0C0C, "dropped write");

    check("scoreboard empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcu_tile_port.md
Name: bcu_tile_port

Overview:
- Consumes the BCU-side M68K selects from the address decoder: bcu_flip_cs, tile_ofs_cs, tile_attr_cs, tile_num_cs and scroll_cs.
- Holds the tile VRAM pointer, the BCU flip register and the scroll registers.
- Services M68K reads/writes to tile VRAM through a pointer-indirect port and generates DTACK.
- Exposes a second, read-only VRAM port and the scroll/flip registers to the tilemap renderer.

Parameters:
- ADDR_W, 14: tile VRAM word-pair address width (16384 entries).
- N_SCROLL, 8: scroll registers (4 layers x X/Y), selected by cpu_a[3:1].

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_a  in  4  M68K address bits [4:1]
- cpu_rw  in  1  1 = read, 0 = write
- cpu_uds_n  in  1  upper byte strobe
- cpu_lds_n  in  1  lower byte strobe
- cpu_dout  in  16  data driven by the CPU
- bcu_flip_cs, tile_ofs_cs, tile_attr_cs, tile_num_cs, scroll_cs  in  1 each  decoded selects (already qualified by AS)
- cpu_din  out  16  read data to the CPU
- dtack_n  out  1  data acknowledge, active low
- vid_addr  in  ADDR_W  renderer read address
- vid_data  out  32  {attr[15:0], num[15:0]}, one-cycle latency
- scroll  out  16*N_SCROLL  packed scroll registers; reg i occupies bits [16i+15:16i]
- bcu_flip  out  16  flip register

Behaviour:
- Reset values: dtack_n=1, cpu_din=0, tile_ofs=0, bcu_flip=0, all scroll regs=0, FSM=IDLE. VRAM contents are not cleared.
- any_cs = OR of the five selects. Selects are mutually exclusive by decode. If several are asserted anyway, priority is tile_attr > tile_num > tile_ofs > scroll > flip.
- FSM states and transitions:
  - IDLE: on any_cs rising edge (registered previous value = 0), latch the select, rw, strobes, cpu_a and cpu_dout, then go to ADDR.
  - ADDR: VRAM address = tile_ofs[ADDR_W-1:0]. A RAM write is issued here, with byte enables taken from the strobes. Go to DATA.
  - DATA: capture read data into cpu_din. Register writes take effect here. Go to ACK.
  - ACK: dtack_n=0; hold while any_cs=1. When any_cs=0, set dtack_n=1 and return to IDLE.
- Latency: dtack_n falls 3 clocks after the cs rising edge and rises 1 clock after cs falls.
- Read data per select:
  - tile_attr: VRAM[ofs][31:16]
  - tile_num: VRAM[ofs][15:0]
  - tile_ofs: the offset register
  - scroll: scroll[cpu_a[3:1]]
  - bcu_flip: the flip register
- Writes:
  - tile_ofs: the write updates the pointer. The pointer does not auto-increment, and bits above ADDR_W are stored but ignored for addressing.
  - Byte strobes mask writes to both RAM halves and registers. A write with both strobes high is acknowledged and changes nothing.
- Pointer wrap: offset 0x4000 addresses entry 0.
- Video port: registered read of vid_addr, with vid_data valid the next clock. It is independent of CPU activity. On a same-address CPU write and video read in the same cycle, video returns the old data.
- Reset mid-access: FSM returns to IDLE and dtack_n=1. A pending write is dropped if reset arrives before ADDR.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, ADDR, DATA, ACK}
  - TILE_ADDR_W = 14
  - N_SCROLL = 8
- Sub-module bcu_tile_ram: true dual-port 16K x 32 RAM.
  - Port A: read/write with 4 byte enables.
  - Port B: read-only.
  - One-cycle registered reads on both ports.

Test Plan:
- Reset: assert reset mid-ACK -> dtack_n=1, scroll=0, bcu_flip=0, FSM=IDLE on the next clock.
- Pointer write/read: write tile_ofs=0x0123, tile_attr=0xA5A5, tile_num=0x5A5A; read back attr and num -> 0xA5A5 and 0x5A5A; vid_addr=0x123 -> vid_data=0xA5A55A5A one clock later.
- Byte mask: write tile_num=0xFFFF with only lds_n=0 over existing 0x1234 -> readback 0x12FF; dtack_n low 3 clocks after cs.
- Wrap: tile_ofs=0x4005, write attr=0xBEEF -> vid_addr=0x0005 shows attr 0xBEEF.
- Scroll bank: write 0x0100+i to scroll cpu_a[3:1]=i for i=0..7 -> scroll reg i=0x0100+i, and each reads back the same.
- Handshake hold: keep cs high for 10 clocks -> dtack_n stays 0 until cs falls and rises the next clock; a second cs pulse starts a fresh 3-clock access.
